// File: rtl/input_debouncer.sv
// input_debouncer: per-line 2-FF synchronizer, saturating debounce counter and
// registered rise/fall/changed pulses for switch lines feeding the 4-to-2 encoder.
module input_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_WIDTH       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    // Terminal count: the level flips on the edge where the counter already holds this value.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]                sync1_q;
    logic [WIDTH-1:0]                sync2_q;
    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0]                deb_q;
    logic [WIDTH-1:0]                deb_d;
    logic [WIDTH-1:0]                rise_q;
    logic [WIDTH-1:0]                rise_d;
    logic [WIDTH-1:0]                fall_q;
    logic [WIDTH-1:0]                fall_d;
    logic                            changed_q;
    logic                            changed_d;

    // Two-stage synchronizer for the asynchronous raw lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count while sync2 disagrees with the stable level, flip at terminal count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Edge pulses derived from the next stable level so they line up with the new output value.
    always_comb begin
        rise_d    = deb_d & ~deb_q;
        fall_d    = ~deb_d & deb_q;
        changed_d = |(rise_d | fall_d);
    end

    // Debounce counters, stable levels and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            deb_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign debounced_out = deb_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign changed       = changed_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vectors with hand-computed expectations for
// input_debouncer (DEBOUNCE_CYCLES=4 main instance, DEBOUNCE_CYCLES=1 side instance).
module tb_input_debouncer;

    logic       clk;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] debounced_out, rise_pulse, fall_pulse;
    logic       changed;
    logic [3:0] deb1_out, rise1, fall1;
    logic       changed1;

    int n_checks = 0;
    int n_errors = 0;

    int rise_events    = 0;
    int fall_events    = 0;
    int changed_events = 0;
    int repeat_pulses  = 0;
    logic [3:0] prev_rise = '0;
    logic [3:0] prev_fall = '0;

    input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .debounced_out(debounced_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .changed(changed)
    );

    input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .debounced_out(deb1_out), .rise_pulse(rise1),
        .fall_pulse(fall1), .changed(changed1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Pulse monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            rise_events    <= rise_events + $countones(rise_pulse);
            fall_events    <= fall_events + $countones(fall_pulse);
            changed_events <= changed_events + int'(changed);
            if (((rise_pulse & prev_rise) | (fall_pulse & prev_fall)) != 4'b0000)
                repeat_pulses <= repeat_pulses + 1;
        end
        prev_rise <= rise_pulse;
        prev_fall <= fall_pulse;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    function automatic logic [1:0] enc4(input logic [3:0] v);
        case (v)
            4'b0001: enc4 = 2'd0;
            4'b0010: enc4 = 2'd1;
            4'b0100: enc4 = 2'd2;
            4'b1000: enc4 = 2'd3;
            default: enc4 = 2'd0;
        endcase
    endfunction

    int snap_r, snap_f, snap_c;
    logic [3:0] sweep [4];

    initial begin
        reset  = 1'b1;
        raw_in = 4'b0000;
        tick(2);
        // Reset state
        check_val("reset_deb", debounced_out, 4'b0000);
        check_val("reset_pulses", {rise_pulse, fall_pulse, changed}, 9'd0);
        reset = 1'b0;

        // 1: single rise, latency 2+4 edges; D=1 instance flips at edge 3
        raw_in = 4'b0001;
        tick(2);
        check_val("d1_before", deb1_out, 4'b0000);
        tick(1);
        check_val("d1_edge3", deb1_out, 4'b0001);
        check_val("d1_rise", rise1, 4'b0001);
        tick(2);
        check_val("t1_edge5_deb", debounced_out, 4'b0000);
        tick(1);
        check_val("t1_edge6_deb", debounced_out, 4'b0001);
        check_val("t1_rise", rise_pulse, 4'b0001);
        check_val("t1_fall", fall_pulse, 4'b0000);
        check_val("t1_changed", changed, 1'b1);
        tick(1);
        check_val("t1_rise_off", rise_pulse, 4'b0000);
        check_val("t1_changed_off", changed, 1'b0);
        check_val("t1_deb_hold", debounced_out, 4'b0001);

        // 2: 3-cycle glitch on bit 2 is rejected
        snap_c = changed_events;
        raw_in = 4'b0101;
        tick(3);
        raw_in = 4'b0001;
        tick(2);
        check_val("t2_cnt_peak", dut.cnt_q[2], 4'd3);
        tick(1);
        check_val("t2_cnt_clear", dut.cnt_q[2], 4'd0);
        tick(4);
        check_val("t2_deb", debounced_out, 4'b0001);
        check_val("t2_no_pulse", changed_events - snap_c, 0);

        // 3: simultaneous rises, then opposite-direction flips
        do_reset();
        raw_in = 4'b1010;
        tick(5);
        check_val("t3_edge5_deb", debounced_out, 4'b0000);
        tick(1);
        check_val("t3_deb", debounced_out, 4'b1010);
        check_val("t3_rise", rise_pulse, 4'b1010);
        check_val("t3_changed", changed, 1'b1);
        tick(1);
        check_val("t3_changed_off", changed, 1'b0);
        raw_in = 4'b0110;
        tick(6);
        check_val("t3b_deb", debounced_out, 4'b0110);
        check_val("t3b_rise", rise_pulse, 4'b0100);
        check_val("t3b_fall", fall_pulse, 4'b1000);
        check_val("t3b_changed", changed, 1'b1);
        tick(1);
        check_val("t3b_off", {rise_pulse, fall_pulse, changed}, 9'd0);

        // 4: bounce then stable 1 on bit 0
        do_reset();
        tick(1);
        snap_r = rise_events;
        raw_in = 4'b0001; tick(1);
        raw_in = 4'b0000; tick(1);
        raw_in = 4'b0001; tick(1);
        raw_in = 4'b0000; tick(1);
        raw_in = 4'b0001;
        tick(5);
        check_val("t4_edge5_deb", debounced_out, 4'b0000);
        tick(1);
        check_val("t4_edge6_deb", debounced_out, 4'b0001);
        check_val("t4_rise", rise_pulse, 4'b0001);
        tick(2);
        check_val("t4_single_rise", rise_events - snap_r, 1);

        // 5: asynchronous reset mid-count
        do_reset();
        raw_in = 4'b1000;
        tick(6);
        check_val("t5_pre_deb", debounced_out, 4'b1000);
        raw_in = 4'b1001;
        tick(4);
        check_val("t5_cnt_mid", dut.cnt_q[0], 4'd2);
        #2 reset = 1'b1;
        #1;
        check_val("t5_async_deb", debounced_out, 4'b0000);
        check_val("t5_async_cnt", dut.cnt_q[0], 4'd0);
        #1 reset = 1'b0;
        tick(5);
        check_val("t5_relat5", debounced_out, 4'b0000);
        tick(1);
        check_val("t5_relat6", debounced_out, 4'b1001);
        check_val("t5_rise", rise_pulse, 4'b1001);

        // 6: one-hot sweep into the encoder, then back to idle
        do_reset();
        tick(1);
        snap_r = rise_events;
        snap_f = fall_events;
        snap_c = changed_events;
        sweep[0] = 4'b0001;
        sweep[1] = 4'b0010;
        sweep[2] = 4'b0100;
        sweep[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            raw_in = sweep[k];
            tick(10);
            check_val($sformatf("t6_deb%0d", k), debounced_out, sweep[k]);
            check_val($sformatf("t6_enc%0d", k), enc4(debounced_out), k);
        end
        raw_in = 4'b0000;
        tick(10);
        check_val("t6_rises", rise_events - snap_r, 4);
        check_val("t6_falls", fall_events - snap_f, 4);
        check_val("t6_changed", changed_events - snap_c, 5);
        check_val("no_repeat_pulse", repeat_pulses, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
